sha1_round_engine: RTL and testbench

//  SHA-1 compression core; sits directly downstream of the W-schedule engine.

---
 rtl/sha1_round_engine.sv | 105 ++++++++++
 tb/tb_sha1_round_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sha1_round_engine.sv
// SHA-1 compression core: runs the rounds on A..E using one schedule word per cycle,
// then folds the working registers into the chaining state H0..H4.
module sha1_round_engine #(
    parameter int NUM_ROUNDS = 80
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         start,
    input  logic [31:0]  w_in,
    output logic         w_next,
    output logic         busy,
    output logic         done,
    output logic [159:0] hout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    localparam logic [6:0]   LAST_T    = 7'(NUM_ROUNDS - 1);
    localparam logic [159:0] IV_PACKED = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

    logic [1:0]  stateReg;
    logic [6:0]  tReg;
    logic        doneReg;
    logic [31:0] hReg [5];
    logic [31:0] wkReg [5];   // A..E at indices 0..4
    logic [31:0] ivWord [5];

    logic [31:0] fVal;
    logic [31:0] kVal;
    logic [31:0] tVal;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_words
            assign ivWord[gi]               = IV_PACKED[159-32*gi -: 32];
            assign hout[159-32*gi -: 32]    = hReg[gi];
        end
    endgenerate

    // Round function and constant selected by t/20.
    always_comb begin
        fVal = wkReg[1] ^ wkReg[2] ^ wkReg[3];
        kVal = 32'hCA62C1D6;
        if (tReg < 7'd20) begin
            fVal = (wkReg[1] & wkReg[2]) | (~wkReg[1] & wkReg[3]);
            kVal = 32'h5A827999;
        end else if (tReg < 7'd40) begin
            kVal = 32'h6ED9EBA1;
        end else if (tReg < 7'd60) begin
            fVal = (wkReg[1] & wkReg[2]) | (wkReg[1] & wkReg[3]) | (wkReg[2] & wkReg[3]);
            kVal = 32'h8F1BBCDC;
        end
        tVal = {wkReg[0][26:0], wkReg[0][31:27]} + fVal + wkReg[4] + kVal + w_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
            tReg     <= 7'd0;
            doneReg  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                hReg[i]  <= ivWord[i];
                wkReg[i] <= 32'd0;
            end
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (init) begin
                        for (int i = 0; i < 5; i++) hReg[i] <= ivWord[i];
                    end
                    if (start) begin
                        // A simultaneous init means this block starts from IV, not the old H.
                        for (int i = 0; i < 5; i++) wkReg[i] <= init ? ivWord[i] : hReg[i];
                        tReg     <= 7'd0;
                        stateReg <= ROUND;
                    end
                end
                ROUND: begin
                    wkReg[4] <= wkReg[3];
                    wkReg[3] <= wkReg[2];
                    wkReg[2] <= {wkReg[1][1:0], wkReg[1][31:2]};
                    wkReg[1] <= wkReg[0];
                    wkReg[0] <= tVal;
                    tReg     <= tReg + 7'd1;
                    if (tReg == LAST_T) stateReg <= FINAL;
                end
                FINAL: begin
                    for (int i = 0; i < 5; i++) hReg[i] <= hReg[i] + wkReg[i];
                    doneReg  <= 1'b1;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign w_next = (stateReg == ROUND);
    assign busy   = (stateReg != IDLE);
    assign done   = doneReg;

endmodule

// File: tb/tb_sha1_round_engine.sv
// Bench for sha1_round_engine: models the W-schedule engine and checks digests via a scoreboard.
module tb_sha1_round_engine;

    logic         clk = 1'b0;
    logic         reset, init, start;
    logic [31:0]  w_in;
    logic         w_next, busy, done;
    logic [159:0] hout;

    always #5 clk = ~clk;

    sha1_round_engine #(.NUM_ROUNDS(80)) dut (
        .clk    (clk),
        .reset  (reset),
        .init   (init),
        .start  (start),
        .w_in   (w_in),
        .w_next (w_next),
        .busy   (busy),
        .done   (done),
        .hout   (hout)
    );

    localparam logic [159:0] IV_D  = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
    localparam logic [159:0] ABC_D = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] TWO_D = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

    typedef struct {
        logic [159:0] digest;
        bit           chk;
        string        name;
    } exp_t;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] msg [3][16];
    logic [31:0] wArr [80];
    int          wIdx = 0;
    int          negCnt = 0;
    int          startNeg = 0;
    int          doneCnt = 0;
    int          wnCnt = 0;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic loadBlock(input int b);
        for (int t = 0; t < 16; t++) wArr[t] = msg[b][t];
        for (int t = 16; t < 80; t++)
            wArr[t] = rotl1(wArr[t-3] ^ wArr[t-8] ^ wArr[t-14] ^ wArr[t-16]);
        wIdx = 0;
    endtask

    // Issues one block; extra=1 adds start/init pulses at rounds 10, 79 and in FINAL.
    task automatic runBlock(input int b, input bit doInit, input bit chk,
                            input logic [159:0] dig, input string name, input bit extra);
        int budget;
        exp_t e;
        loadBlock(b);
        e.digest = dig;
        e.chk    = chk;
        e.name   = name;
        expQ.push_back(e);
        wnCnt   = 0;
        doneCnt = 0;
        start   = 1'b1;
        init    = doInit;
        @(posedge clk); #2;
        start = 1'b0;
        init  = 1'b0;
        for (int c = 1; c <= 81; c++) begin
            start = extra && (c == 11 || c == 80 || c == 81);
            init  = start;
            @(posedge clk); #2;
        end
        start  = 1'b0;
        init   = 1'b0;
        budget = 0;
        while (expQ.size() != 0 && budget < 20) begin
            @(posedge clk); #2;
            budget++;
        end
        if (expQ.size() != 0) begin
            check({name, " done timeout"}, 160'(expQ.size()), 160'd0);
            expQ.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        init  = 1'b0;
        start = 1'b0;
        w_in  = 32'd0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 16; i++) msg[b][i] = 32'd0;
        msg[0][0]  = 32'h61626380;
        msg[0][15] = 32'h00000018;
        msg[1][0]  = 32'h61626364; msg[1][1]  = 32'h62636465;
        msg[1][2]  = 32'h63646566; msg[1][3]  = 32'h64656667;
        msg[1][4]  = 32'h65666768; msg[1][5]  = 32'h66676869;
        msg[1][6]  = 32'h6768696a; msg[1][7]  = 32'h68696a6b;
        msg[1][8]  = 32'h696a6b6c; msg[1][9]  = 32'h6a6b6c6d;
        msg[1][10] = 32'h6b6c6d6e; msg[1][11] = 32'h6c6d6e6f;
        msg[1][12] = 32'h6d6e6f70; msg[1][13] = 32'h6e6f7071;
        msg[1][14] = 32'h80000000;
        msg[2][15] = 32'h000001C0;
        loadBlock(0);

        // W-schedule model plus done monitor, both on the falling edge.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                negCnt++;
                w_in = (wIdx < 80) ? wArr[wIdx] : 32'd0;
                if (w_next) begin
                    wIdx++;
                    wnCnt++;
                end
                if (start && !busy && !reset) startNeg = negCnt;
                if (done) begin
                    doneCnt++;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected done: hout %h with nothing pending", hout);
                    end else begin
                        e = expQ.pop_front();
                        check({e.name, " latency"}, 160'(negCnt - startNeg), 160'd82);
                        if (e.chk) check({e.name, " digest"}, hout, e.digest);
                        else $display("info %s intermediate H %h", e.name, hout);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        check("reset busy",   160'(busy),   160'd0);
        check("reset done",   160'(done),   160'd0);
        check("reset w_next", 160'(w_next), 160'd0);
        check("reset hout",   hout,         IV_D);
        reset = 1'b0;
        @(posedge clk); #2;

        runBlock(0, 1'b1, 1'b1, ABC_D, "abc", 1'b0);

        runBlock(1, 1'b1, 1'b0, 160'd0, "two blk1", 1'b0);
        runBlock(2, 1'b0, 1'b1, TWO_D, "two blk2", 1'b0);

        runBlock(0, 1'b1, 1'b1, ABC_D, "abc extra pulses", 1'b1);
        repeat (5) @(posedge clk);
        #2;
        check("extra w_next count", 160'(wnCnt),   160'd80);
        check("extra done count",   160'(doneCnt), 160'd1);

        loadBlock(0);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("round 40 busy", 160'(busy), 160'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        check("abort busy",   160'(busy),   160'd0);
        check("abort done",   160'(done),   160'd0);
        check("abort w_next", 160'(w_next), 160'd0);
        check("abort hout",   hout,         IV_D);
        reset   = 1'b0;
        doneCnt = 0;
        repeat (90) @(posedge clk);
        #2;
        check("abort no done", 160'(doneCnt), 160'd0);
        runBlock(0, 1'b0, 1'b1, ABC_D, "abc after abort", 1'b0);

        runBlock(0, 1'b1, 1'b1, ABC_D, "init+start", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
